cc_miss_req_unit: RTL and testbench
===================================

CC_MISS_REQ_UNIT -- requirements
Module: cc_miss_req_unit

Interface
REQ-001 Parameter: DEPTH_LG2, default 2, log2 of miss-address FIFO depth (default depth 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 miss_req_valid_i  input  1  tag-compare stage presents a miss.
REQ-005 miss_req_addr_i  input  32  byte address of the missing access.
REQ-006 miss_req_ready_o  output  1  miss accepted this cycle when high with valid.
REQ-007 mem_arvalid_o  output  1  AXI AR valid to memory.
REQ-008 mem_arready_i  input  1  AXI AR ready from memory.
REQ-009 mem_araddr_o  output  32  AR address, 8-byte aligned (critical word first).
REQ-010 mem_arlen_o  output  4  burst length minus one.
REQ-011 mem_arsize_o  output  3  beat size code.
REQ-012 mem_arburst_o  output  2  burst type.
REQ-013 miss_addr_fifo_empty_o  output  1  no outstanding miss address held.
REQ-014 miss_addr_fifo_rdata_o  output  32  head entry, full original address.
REQ-015 miss_addr_fifo_rden_i  input  1  data-fill stage pops head entry.
REQ-016 outstanding_cnt_o  output  DEPTH_LG2+1  FIFO occupancy.
REQ-017 underflow_o  output  1  sticky flag: pop attempted while empty.

Function
REQ-018 Accept handshake: miss_req_ready_o SHALL equal (occupancy < 2^DEPTH_LG2) AND NOT mem_arvalid_o; a miss is accepted in a cycle where valid and ready are both high.
REQ-019 On accept, the address SHALL be pushed into the FIFO tail and loaded into the AR register in the same edge.
REQ-020 AR state machine SHALL have two states: IDLE (arvalid=0) and REQ (arvalid=1); IDLE->REQ on accept; REQ->IDLE on edge with arready=1; REQ holds otherwise, with araddr stable.
REQ-021 Accept-to-arvalid latency SHALL be exactly one cycle; at most one AR SHALL be pending.
REQ-022 mem_araddr_o SHALL be {addr[31:3], 3'b000}; mem_arlen_o SHALL be 4'd7; mem_arsize_o SHALL be 3'b011; mem_arburst_o SHALL be 2'b10 (WRAP), constant.
REQ-023 FIFO SHALL be first-word-fall-through: miss_addr_fifo_rdata_o combinationally reflects head entry; value undefined-but-stable (last written) when empty.
REQ-024 Pop SHALL occur on an edge with rden=1 and empty=0; the head pointer advances modulo depth.
REQ-025 Write and read pointers SHALL be DEPTH_LG2 bits and wrap from depth-1 to 0; occupancy held in separate DEPTH_LG2+1-bit counter.
REQ-026 Simultaneous push and pop in one cycle SHALL leave occupancy unchanged and update both pointers.
REQ-027 Push when full SHALL be impossible (ready low); pop when empty SHALL not change pointers or occupancy and SHALL set underflow_o, held until reset.
REQ-028 Pop of an entry whose AR is still pending SHALL be legal and SHALL not affect the AR register.
REQ-029 miss_addr_fifo_empty_o SHALL equal (occupancy == 0).

Reset
REQ-030 On rst_n low, asynchronously: mem_arvalid_o=0, AR register=0, pointers=0, occupancy=0, underflow_o=0; therefore empty=1, ready=1 (after release), outstanding_cnt_o=0.
REQ-031 Reset mid-burst SHALL discard pending AR and all FIFO entries; no AR reissued after release.
REQ-032 FIFO storage array need not be reset.

Verification
REQ-033 Single miss: addr 0x0001_2348, arready high -> ready 1 at accept, arvalid 1 next cycle with araddr 0x0001_2348, arlen 7, arsize 3, arburst 2; arvalid 0 after; empty 0, rdata 0x0001_2348.
REQ-034 AR backpressure: arready low 5 cycles after accept of 0x0000_0F7C -> arvalid and araddr 0x0000_0F78 stable 5 cycles, ready 0 throughout, new valid not accepted.
REQ-035 Fill to full: four misses 0x100,0x200,0x300,0x400 with arready=1, no pops -> outstanding_cnt_o 4, ready 0; pops return 0x100,0x200,0x300,0x400 in order, then empty 1.
REQ-036 Wrap and concurrent push/pop: 6 misses interleaved with pops at occupancy 2 -> count stays 2 on concurrent cycles, pointer wrap preserves order, no entry lost.
REQ-037 Underflow: rden=1 while empty -> pointers unchanged, underflow_o 1 next edge, cleared only by rst_n.
REQ-038 Reset mid-operation: assert rst_n low while arvalid=1 and occupancy 3 -> arvalid 0 and empty 1 immediately (asynchronous), no AR after release.

Source files
------------

// File: rtl/cc_miss_req_unit.sv
// Miss request unit: turns accepted cache misses into one WRAP AXI AR burst each and
// queues the original miss addresses for the data-fill stage in a fall-through FIFO.
module cc_miss_req_unit #(
   parameter int DEPTH_LG2 = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 miss_req_valid_i,
   input  logic [31:0]          miss_req_addr_i,
   output logic                 miss_req_ready_o,
   output logic                 mem_arvalid_o,
   input  logic                 mem_arready_i,
   output logic [31:0]          mem_araddr_o,
   output logic [3:0]           mem_arlen_o,
   output logic [2:0]           mem_arsize_o,
   output logic [1:0]           mem_arburst_o,
   output logic                 miss_addr_fifo_empty_o,
   output logic [31:0]          miss_addr_fifo_rdata_o,
   input  logic                 miss_addr_fifo_rden_i,
   output logic [DEPTH_LG2:0]   outstanding_cnt_o,
   output logic                 underflow_o
);

   localparam int DEPTH = 1 << DEPTH_LG2;
   localparam logic [DEPTH_LG2:0] FULL_CNT = (DEPTH_LG2 + 1)'(DEPTH);

   // Handshake: a miss transfers on a rising edge where miss_req_valid_i and
   // miss_req_ready_o are both high; an AR transfers where mem_arvalid_o and
   // mem_arready_i are both high. The AR register is the FSM's only payload.
   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } ar_state_t;

   ar_state_t              state_q;
   ar_state_t              state_d;
   logic [31:0]            ar_addr_q;
   logic [31:0]            mem [DEPTH];
   logic [DEPTH_LG2-1:0]   wr_ptr;
   logic [DEPTH_LG2-1:0]   rd_ptr;
   logic [DEPTH_LG2:0]     count;
   logic                   underflow_q;
   logic                   accept;
   logic                   pop;
   logic                   empty;

   assign empty                  = (count == '0);
   assign mem_arvalid_o          = (state_q == REQ);
   assign miss_req_ready_o       = (count < FULL_CNT) && !mem_arvalid_o;
   assign accept                 = miss_req_valid_i && miss_req_ready_o;
   assign pop                    = miss_addr_fifo_rden_i && !empty;

   assign mem_araddr_o           = ar_addr_q;
   assign mem_arlen_o            = 4'd7;
   assign mem_arsize_o           = 3'b011;
   assign mem_arburst_o          = 2'b10;
   assign miss_addr_fifo_empty_o = empty;
   assign miss_addr_fifo_rdata_o = mem[rd_ptr];
   assign outstanding_cnt_o      = count;
   assign underflow_o            = underflow_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = REQ;
         REQ:     if (mem_arready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ar_addr_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) ar_addr_q <= {miss_req_addr_i[31:3], 3'b000};
      end
   end

   // Storage is left unreset; only pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= miss_req_addr_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         underflow_q <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + DEPTH_LG2'(1);
         if (pop)    rd_ptr <= rd_ptr + DEPTH_LG2'(1);
         case ({accept, pop})
            2'b10:   count <= count + (DEPTH_LG2 + 1)'(1);
            2'b01:   count <= count - (DEPTH_LG2 + 1)'(1);
            default: count <= count;
         endcase
         if (miss_addr_fifo_rden_i && empty) underflow_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cc_miss_req_unit.sv
// Directed bench for cc_miss_req_unit: drivers push expected AR and FIFO data into
// queues; a negedge monitor compares them on each AR handshake and each FIFO pop.
module tb_cc_miss_req_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        miss_req_valid_i;
   logic [31:0] miss_req_addr_i;
   logic        miss_req_ready_o;
   logic        mem_arvalid_o;
   logic        mem_arready_i;
   logic [31:0] mem_araddr_o;
   logic [3:0]  mem_arlen_o;
   logic [2:0]  mem_arsize_o;
   logic [1:0]  mem_arburst_o;
   logic        miss_addr_fifo_empty_o;
   logic [31:0] miss_addr_fifo_rdata_o;
   logic        miss_addr_fifo_rden_i;
   logic [2:0]  outstanding_cnt_o;
   logic        underflow_o;

   int checks = 0;
   int failures = 0;
   logic [31:0] ar_exp_q[$];
   logic [31:0] fifo_exp_q[$];

   cc_miss_req_unit #(.DEPTH_LG2(2)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .miss_req_valid_i       (miss_req_valid_i),
      .miss_req_addr_i        (miss_req_addr_i),
      .miss_req_ready_o       (miss_req_ready_o),
      .mem_arvalid_o          (mem_arvalid_o),
      .mem_arready_i          (mem_arready_i),
      .mem_araddr_o           (mem_araddr_o),
      .mem_arlen_o            (mem_arlen_o),
      .mem_arsize_o           (mem_arsize_o),
      .mem_arburst_o          (mem_arburst_o),
      .miss_addr_fifo_empty_o (miss_addr_fifo_empty_o),
      .miss_addr_fifo_rdata_o (miss_addr_fifo_rdata_o),
      .miss_addr_fifo_rden_i  (miss_addr_fifo_rden_i),
      .outstanding_cnt_o      (outstanding_cnt_o),
      .underflow_o            (underflow_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: sampled mid-cycle, these conditions commit on the next rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_arvalid_o && mem_arready_i) begin
            if (ar_exp_q.size() == 0) begin
               check("ar_unexpected", 32'd1, 32'd0);
            end else begin
               check("ar_addr", mem_araddr_o, ar_exp_q.pop_front());
               check("ar_len", {28'd0, mem_arlen_o}, 32'd7);
               check("ar_size", {29'd0, mem_arsize_o}, 32'd3);
               check("ar_burst", {30'd0, mem_arburst_o}, 32'd2);
            end
         end
         if (miss_addr_fifo_rden_i && !miss_addr_fifo_empty_o) begin
            if (fifo_exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
            else check("pop_data", miss_addr_fifo_rdata_o, fifo_exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_miss(input logic [31:0] addr);
      int n = 0;
      miss_req_valid_i = 1'b1;
      miss_req_addr_i  = addr;
      while (!miss_req_ready_o && n < 50) begin
         tick();
         n++;
      end
      if (!miss_req_ready_o) begin
         check("accept_timeout", 32'd0, 32'd1);
      end else begin
         ar_exp_q.push_back({addr[31:3], 3'b000});
         fifo_exp_q.push_back(addr);
      end
      tick();
      miss_req_valid_i = 1'b0;
   endtask

   task automatic pop_one();
      miss_addr_fifo_rden_i = 1'b1;
      tick();
      miss_addr_fifo_rden_i = 1'b0;
   endtask

   task automatic wait_ar_idle();
      int n = 0;
      while (mem_arvalid_o && n < 50) begin
         tick();
         n++;
      end
      check("ar_idle_timeout", {31'd0, mem_arvalid_o}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      miss_req_valid_i = 1'b0;
      miss_req_addr_i = '0;
      mem_arready_i = 1'b1;
      miss_addr_fifo_rden_i = 1'b0;
      #2;
      check("rst_arvalid", {31'd0, mem_arvalid_o}, 32'd0);
      check("rst_empty", {31'd0, miss_addr_fifo_empty_o}, 32'd1);
      check("rst_cnt", {29'd0, outstanding_cnt_o}, 32'd0);
      check("rst_underflow", {31'd0, underflow_o}, 32'd0);
      check("rst_araddr", mem_araddr_o, 32'd0);
      #10 rst_n = 1'b1;
      tick();
      check("rst_ready", {31'd0, miss_req_ready_o}, 32'd1);

      // Single miss
      check("single_ready", {31'd0, miss_req_ready_o}, 32'd1);
      send_miss(32'h0001_2348);
      check("single_arvalid", {31'd0, mem_arvalid_o}, 32'd1);
      check("single_araddr", mem_araddr_o, 32'h0001_2348);
      tick();
      check("single_arvalid_off", {31'd0, mem_arvalid_o}, 32'd0);
      check("single_empty", {31'd0, miss_addr_fifo_empty_o}, 32'd0);
      check("single_rdata", miss_addr_fifo_rdata_o, 32'h0001_2348);
      pop_one();
      check("single_empty_after", {31'd0, miss_addr_fifo_empty_o}, 32'd1);

      // AR backpressure; a competing request must not be accepted
      mem_arready_i = 1'b0;
      send_miss(32'h0000_0F7C);
      miss_req_valid_i = 1'b1;
      miss_req_addr_i  = 32'hDEAD_0000;
      for (int i = 0; i < 5; i++) begin
         check("bp_arvalid", {31'd0, mem_arvalid_o}, 32'd1);
         check("bp_araddr", mem_araddr_o, 32'h0000_0F78);
         check("bp_ready", {31'd0, miss_req_ready_o}, 32'd0);
         tick();
      end
      miss_req_valid_i = 1'b0;
      check("bp_cnt", {29'd0, outstanding_cnt_o}, 32'd1);
      mem_arready_i = 1'b1;
      tick();
      check("bp_release", {31'd0, mem_arvalid_o}, 32'd0);
      pop_one();

      // Fill to full
      send_miss(32'h100);
      send_miss(32'h200);
      send_miss(32'h300);
      send_miss(32'h400);
      wait_ar_idle();
      check("full_cnt", {29'd0, outstanding_cnt_o}, 32'd4);
      check("full_ready", {31'd0, miss_req_ready_o}, 32'd0);
      for (int i = 0; i < 4; i++) pop_one();
      check("full_drained", {31'd0, miss_addr_fifo_empty_o}, 32'd1);

      // Wrap with concurrent push and pop at occupancy 2
      send_miss(32'h500);
      send_miss(32'h600);
      wait_ar_idle();
      check("wrap_cnt_pre", {29'd0, outstanding_cnt_o}, 32'd2);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         a = 32'h700 + 32'(i) * 32'h100;
         miss_req_valid_i = 1'b1;
         miss_req_addr_i = a;
         miss_addr_fifo_rden_i = 1'b1;
         check("wrap_ready", {31'd0, miss_req_ready_o}, 32'd1);
         ar_exp_q.push_back(a);
         fifo_exp_q.push_back(a);
         tick();
         miss_req_valid_i = 1'b0;
         miss_addr_fifo_rden_i = 1'b0;
         check("wrap_cnt", {29'd0, outstanding_cnt_o}, 32'd2);
         wait_ar_idle();
      end
      pop_one();
      pop_one();
      check("wrap_empty", {31'd0, miss_addr_fifo_empty_o}, 32'd1);

      // Underflow
      pop_one();
      check("uf_flag", {31'd0, underflow_o}, 32'd1);
      check("uf_cnt", {29'd0, outstanding_cnt_o}, 32'd0);
      send_miss(32'h0000_0B04);
      wait_ar_idle();
      check("uf_rdata", miss_addr_fifo_rdata_o, 32'h0000_0B04);
      pop_one();
      tick();
      check("uf_sticky", {31'd0, underflow_o}, 32'd1);

      // Asynchronous reset with AR pending and occupancy 3
      send_miss(32'h0000_1000);
      send_miss(32'h0000_2000);
      wait_ar_idle();
      mem_arready_i = 1'b0;
      send_miss(32'h0000_3000);
      check("pre_rst_cnt", {29'd0, outstanding_cnt_o}, 32'd3);
      check("pre_rst_arvalid", {31'd0, mem_arvalid_o}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_arvalid", {31'd0, mem_arvalid_o}, 32'd0);
      check("arst_empty", {31'd0, miss_addr_fifo_empty_o}, 32'd1);
      check("arst_cnt", {29'd0, outstanding_cnt_o}, 32'd0);
      check("arst_underflow", {31'd0, underflow_o}, 32'd0);
      ar_exp_q.delete();
      fifo_exp_q.delete();
      mem_arready_i = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_rst_no_ar", {31'd0, mem_arvalid_o}, 32'd0);
      end
      check("post_rst_ready", {31'd0, miss_req_ready_o}, 32'd1);
      check("ar_queue_left", 32'(ar_exp_q.size()), 32'd0);
      check("fifo_queue_left", 32'(fifo_exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
